mem_stage_lsu: RTL and testbench

//  MEM-stage load/store unit between the EX/MEM pipeline register and the word-wide data memory.

---
 rtl/mem_stage_lsu_pkg.sv | 32 +++
 rtl/mem_stage_lsu_align.sv | 45 ++++
 rtl/mem_stage_lsu.sv | 132 +++++++++++++
 tb/tb_mem_stage_lsu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DMEM_WORDS = 1024;
    localparam int unsigned RD_W       = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_e;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
        logic            misaligned;
        logic            access_fault;
    } wb_payload_t;

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{lane, 3'b000} +: 8];
        half_sel  = rdata[{lane[1], 4'b0000} +: 16];
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_BU:   load_data = {(XLEN-8)'(0), byte_sel};
            F3_HU:   load_data = {(XLEN-16)'(0), half_sel};
            default: load_data = rdata;
        endcase
    end

    // Replace only the addressed lane of the current word with the store data.
    always_comb begin
        merged = wdata;
        case (funct3)
            F3_B: begin
                merged = rdata;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                merged = rdata;
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: fault checks, dmem muxing, SB/SH read-modify-write FSM, MEM/WB register.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_reg_write,
    output logic            stall_o,
    output logic            dmem_rw,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_misaligned,
    output logic            wb_access_fault
);

    lsu_state_e      state;
    wb_payload_t     wb_q, wb_next;
    logic [XLEN-1:0] rmw_addr, rmw_word, rmw_ex_addr;
    logic [RD_W-1:0] rmw_rd;

    logic [XLEN-1:0] word_idx, load_data, merged;
    logic            is_mem, f3_ok, misal_raw, mis, acc, fault, ld, st, sub_st;

    mem_stage_lsu_align u_align (
        .funct3    (ex_funct3),
        .lane      (ex_addr[1:0]),
        .rdata     (dmem_rdata),
        .wdata     (ex_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // Unsigned variants are load-only; anything else is an illegal funct3.
    always_comb begin
        f3_ok = 1'b0;
        case (ex_funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = ex_mem_read;
            default:          f3_ok = 1'b0;
        endcase
    end

    assign word_idx  = {2'b00, ex_addr[XLEN-1:2]};
    assign is_mem    = ex_mem_read | ex_mem_write;
    assign misal_raw = (is_half(ex_funct3) & ex_addr[0])
                     | ((ex_funct3 == F3_W) & (|ex_addr[1:0]));
    assign mis       = ex_valid & is_mem & misal_raw;
    assign acc       = ex_valid & is_mem & ~misal_raw
                     & ((word_idx >= XLEN'(DMEM_WORDS)) | ~f3_ok | (ex_mem_read & ex_mem_write));
    assign fault     = mis | acc;
    assign ld        = ex_valid & ex_mem_read & ~ex_mem_write & ~fault;
    assign st        = ex_valid & ex_mem_write & ~ex_mem_read & ~fault;
    assign sub_st    = st & (ex_funct3 != F3_W);

    // Memory port and stall; reset forces both low so an in-flight write is abandoned.
    always_comb begin
        dmem_addr  = word_idx;
        dmem_wdata = ex_wdata;
        dmem_rw    = 1'b0;
        stall_o    = 1'b0;
        if (state == RMW_WR) begin
            dmem_addr  = rmw_addr;
            dmem_wdata = rmw_word;
            dmem_rw    = ~reset;
        end else begin
            dmem_rw = st & ~sub_st & ~reset;
            stall_o = sub_st & ~reset;
        end
    end

    always_comb begin
        wb_next = '0;
        if (state == RMW_WR) begin
            wb_next.valid = 1'b1;
            wb_next.rd    = rmw_rd;
            wb_next.data  = rmw_ex_addr;
        end else if (ex_valid && !sub_st) begin
            wb_next.valid        = 1'b1;
            wb_next.reg_write    = ex_reg_write & ~fault & ~st;
            wb_next.rd           = ex_rd;
            wb_next.data         = ld ? load_data : ex_addr;
            wb_next.misaligned   = mis;
            wb_next.access_fault = acc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wb_q        <= '0;
            rmw_addr    <= '0;
            rmw_word    <= '0;
            rmw_ex_addr <= '0;
            rmw_rd      <= '0;
        end else begin
            wb_q <= wb_next;
            case (state)
                IDLE: begin
                    if (sub_st) begin
                        state       <= RMW_WR;
                        rmw_addr    <= word_idx;
                        rmw_word    <= merged;
                        rmw_ex_addr <= ex_addr;
                        rmw_rd      <= ex_rd;
                    end
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_valid        = wb_q.valid;
    assign wb_reg_write    = wb_q.reg_write;
    assign wb_rd           = wb_q.rd;
    assign wb_data         = wb_q.data;
    assign wb_misaligned   = wb_q.misaligned;
    assign wb_access_fault = wb_q.access_fault;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a behavioural data memory and a MEM/WB scoreboard.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        af;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall_o, dmem_rw;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_reg_write, wb_misaligned, wb_access_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [31:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .stall_o(stall_o), .dmem_rw(dmem_rw), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_misaligned(wb_misaligned), .wb_access_fault(wb_access_fault)
    );

    assign dmem_rdata = mem[dmem_addr[9:0]];

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (dmem_rw) mem[dmem_addr[9:0]] <= dmem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop one expectation whenever MEM/WB shows a live instruction.
    task automatic check_wb();
        exp_t e;
        if (wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", 64'(wb_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_payload",
                    64'({wb_reg_write, wb_rd, wb_data, wb_misaligned, wb_access_fault}),
                    64'(e));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_wb();
    endtask

    task automatic drive(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rw);
        ex_valid = v; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_funct3 = f3;
        ex_addr = a; ex_wdata = wd; ex_rd = rd; ex_reg_write = rw;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_en = 1'b0;
    endtask

    logic [2:0]  ld_f3   [8];
    logic [31:0] ld_addr [8];
    logic [31:0] ld_exp  [8];

    initial begin
        ld_f3[0] = F3_B;  ld_addr[0] = 32'h12; ld_exp[0] = 32'hFFFFFF80;
        ld_f3[1] = F3_BU; ld_addr[1] = 32'h12; ld_exp[1] = 32'h00000080;
        ld_f3[2] = F3_H;  ld_addr[2] = 32'h12; ld_exp[2] = 32'h00001180;
        ld_f3[3] = F3_HU; ld_addr[3] = 32'h10; ld_exp[3] = 32'h00007F00;
        ld_f3[4] = F3_W;  ld_addr[4] = 32'h10; ld_exp[4] = 32'h11807F00;
        ld_f3[5] = F3_B;  ld_addr[5] = 32'h11; ld_exp[5] = 32'h0000007F;
        ld_f3[6] = F3_H;  ld_addr[6] = 32'h14; ld_exp[6] = 32'hFFFFFFFE;
        ld_f3[7] = F3_HU; ld_addr[7] = 32'h16; ld_exp[7] = 32'h00008001;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb", 64'({wb_valid, wb_reg_write, wb_rd, wb_data, wb_misaligned, wb_access_fault}), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_dmem_rw", 64'(dmem_rw), 64'd0);
        reset = 1'b0;

        // Full-word store goes straight to memory with no stall.
        drive(1'b1, 1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 5'd3, 1'b0);
        #4;
        chk("sw_rw", 64'(dmem_rw), 64'd1);
        chk("sw_addr", 64'(dmem_addr), 64'd4);
        chk("sw_wdata", 64'(dmem_wdata), 64'hDEADBEEF);
        chk("sw_stall", 64'(stall_o), 64'd0);
        sb.push_back('{1'b0, 5'd3, 32'h10, 1'b0, 1'b0});
        step();
        chk("sw_mem", 64'(mem[4]), 64'hDEADBEEF);

        // Byte store: read cycle with stall, then merged write.
        preload(10'd4, 32'h11223344);
        drive(1'b1, 1'b0, 1'b1, F3_B, 32'h13, 32'h000000A5, 5'd4, 1'b1);
        #4;
        chk("sb_stall", 64'(stall_o), 64'd1);
        chk("sb_rd_cycle_rw", 64'(dmem_rw), 64'd0);
        sb.push_back('{1'b0, 5'd4, 32'h13, 1'b0, 1'b0});
        step();
        chk("sb_bubble", 64'(wb_valid), 64'd0);
        chk("sb_wr_stall", 64'(stall_o), 64'd0);
        chk("sb_wr_rw", 64'(dmem_rw), 64'd1);
        chk("sb_wr_addr", 64'(dmem_addr), 64'd4);
        chk("sb_wr_data", 64'(dmem_wdata), 64'hA5223344);
        step();
        chk("sb_mem", 64'(mem[4]), 64'hA5223344);

        // Back-to-back byte store accepted right after the write cycle.
        drive(1'b1, 1'b0, 1'b1, F3_B, 32'h10, 32'h00000077, 5'd5, 1'b0);
        #4;
        chk("sb2_stall", 64'(stall_o), 64'd1);
        sb.push_back('{1'b0, 5'd5, 32'h10, 1'b0, 1'b0});
        step();
        chk("sb2_bubble", 64'(wb_valid), 64'd0);
        step();
        chk("sb2_mem", 64'(mem[4]), 64'hA5223377);

        // Halfword store at the upper lane.
        drive(1'b1, 1'b0, 1'b1, F3_H, 32'h12, 32'h0000BEEF, 5'd6, 1'b0);
        sb.push_back('{1'b0, 5'd6, 32'h12, 1'b0, 1'b0});
        step();
        step();
        chk("sh_mem", 64'(mem[4]), 64'hBEEF3377);

        // Load extraction and extension across lanes.
        preload(10'd4, 32'h11807F00);
        preload(10'd5, 32'h8001FFFE);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, ld_f3[i], ld_addr[i], 32'h0, 5'(i + 16), 1'b1);
            #4;
            chk("ld_rw", 64'(dmem_rw), 64'd0);
            chk("ld_stall", 64'(stall_o), 64'd0);
            sb.push_back('{1'b1, 5'(i + 16), ld_exp[i], 1'b0, 1'b0});
            step();
        end

        // Misaligned accesses.
        drive(1'b1, 1'b1, 1'b0, F3_W, 32'h6, 32'h0, 5'd7, 1'b1);
        #4;
        chk("lw_mis_rw", 64'(dmem_rw), 64'd0);
        sb.push_back('{1'b0, 5'd7, 32'h6, 1'b1, 1'b0});
        step();
        preload(10'd1, 32'hCAFEF00D);
        drive(1'b1, 1'b0, 1'b1, F3_H, 32'h5, 32'h00001234, 5'd8, 1'b0);
        #4;
        chk("sh_mis_rw", 64'(dmem_rw), 64'd0);
        chk("sh_mis_stall", 64'(stall_o), 64'd0);
        sb.push_back('{1'b0, 5'd8, 32'h5, 1'b1, 1'b0});
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        step();
        chk("sh_mis_mem", 64'(mem[1]), 64'hCAFEF00D);

        // Access faults; misalignment wins when both apply.
        drive(1'b1, 1'b0, 1'b1, F3_W, 32'h1000, 32'h12345678, 5'd9, 1'b0);
        #4;
        chk("sw_range_rw", 64'(dmem_rw), 64'd0);
        sb.push_back('{1'b0, 5'd9, 32'h1000, 1'b0, 1'b1});
        step();
        drive(1'b1, 1'b1, 1'b1, F3_W, 32'h20, 32'h0, 5'd10, 1'b1);
        #4;
        chk("rw_both_rw", 64'(dmem_rw), 64'd0);
        sb.push_back('{1'b0, 5'd10, 32'h20, 1'b0, 1'b1});
        step();
        drive(1'b1, 1'b1, 1'b0, F3_W, 32'h1002, 32'h0, 5'd11, 1'b1);
        sb.push_back('{1'b0, 5'd11, 32'h1002, 1'b1, 1'b0});
        step();
        drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 5'd12, 1'b1);
        sb.push_back('{1'b0, 5'd12, 32'h20, 1'b0, 1'b1});
        step();
        drive(1'b1, 1'b0, 1'b1, F3_BU, 32'h20, 32'h0, 5'd14, 1'b0);
        #4;
        chk("sbu_stall", 64'(stall_o), 64'd0);
        sb.push_back('{1'b0, 5'd14, 32'h20, 1'b0, 1'b1});
        step();

        // Non-memory op and bubble.
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h00001234, 32'h0, 5'd13, 1'b1);
        #4;
        chk("alu_rw", 64'(dmem_rw), 64'd0);
        sb.push_back('{1'b1, 5'd13, 32'h00001234, 1'b0, 1'b0});
        step();
        drive(1'b0, 1'b1, 1'b1, F3_W, 32'hFFFF0003, 32'h0, 5'd31, 1'b1);
        step();
        chk("bubble_wb", 64'({wb_valid, wb_reg_write, wb_rd, wb_data, wb_misaligned, wb_access_fault}), 64'd0);

        // Reset during the write cycle abandons the store.
        preload(10'd8, 32'h55667788);
        drive(1'b1, 1'b0, 1'b1, F3_B, 32'h21, 32'h000000EE, 5'd15, 1'b0);
        step();
        chk("rst_rmw_pre_rw", 64'(dmem_rw), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_rmw_rw", 64'(dmem_rw), 64'd0);
        chk("rst_rmw_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_rmw_mem", 64'(mem[8]), 64'h55667788);
        chk("rst_rmw_wb", 64'({wb_valid, wb_reg_write, wb_rd, wb_data, wb_misaligned, wb_access_fault}), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        reset = 1'b0;
        step();
        step();
        chk("rst_rmw_mem_after", 64'(mem[8]), 64'h55667788);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
